mux_nto1_scan: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer. It is the successor to the fixed 8:1 single-bit combinational mux.
- Adds a registered output with a valid/ready handshake.
- Adds a per-channel enable mask.
- Adds an auto-scan mode that round-robins over the enabled channels, with a programmable dwell.
- Sits between a bank of sample sources and a single downstream consumer.

---
 rtl/mux_nto1_scan.sv | 142 ++++++++++++++
 tb/tb_mux_nto1_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: N-channel, W-bit registered multiplexer with a valid/ready
// output, a per-channel enable mask and an auto-scan mode that round-robins
// over the enabled channels, spending dwell+1 accepted words on each one.
module mux_nto1_scan #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = $clog2(NUM_CH),
  parameter int DWELL_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // Output register stage and its word-origin tag.
  logic [DATA_W-1:0]  data_p0;
  logic [SEL_W-1:0]   ch_p0;
  logic               vld_p0;
  logic               scan_p0;

  // Scan state and control.
  logic [SEL_W-1:0]   ptr;
  logic [DWELL_W-1:0] dcnt;
  logic               prev_mode;
  logic               armed;

  // Combinational helpers.
  logic [DATA_W-1:0]  ch_arr [NUM_CH];
  logic               sel_ok;
  logic               entry;
  logic               load;
  logic               accept;
  logic [SEL_W-1:0]   cptr;
  logic [DWELL_W-1:0] cdcnt;

  // Next enabled channel strictly after p, wrapping NUM_CH-1 -> 0. The
  // nearest candidate wins because the loop runs from far to near. If p is
  // the only enabled channel the search lands back on p; with nothing
  // enabled p is returned unchanged.
  function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0]  p,
                                               input logic [NUM_CH-1:0] en);
    logic [SEL_W-1:0] r;
    int idx;
    r = p;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = int'(p) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (en[idx[SEL_W-1:0]]) r = idx[SEL_W-1:0];
    end
    return r;
  endfunction

  for (genvar k = 0; k < NUM_CH; k++) begin : g_split
    assign ch_arr[k] = in_data[k*DATA_W +: DATA_W];
  end

  assign sel_ok = (int'(sel) < NUM_CH);

  // Load/accept decode, plus the scan pointer as it stands once this cycle's
  // accepted scan word has been counted. Capturing from that post-accept
  // pointer keeps the output full every cycle at full throughput while still
  // spending exactly dwell+1 accepted words per channel.
  always_comb begin
    entry  = mode && !prev_mode;
    load   = armed && (!vld_p0 || out_ready);
    accept = vld_p0 && out_ready && scan_p0 && !entry;
    cptr   = ptr;
    cdcnt  = dcnt;
    if (entry) begin
      cptr  = sel_ok ? sel : '0;
      cdcnt = '0;
    end else if (accept) begin
      if (dcnt == dwell) begin
        cptr  = next_en(ptr, ch_en);
        cdcnt = '0;
      end else begin
        cdcnt = dcnt + 1'b1;
      end
    end
  end

  // Output register, scan pointer and dwell counter. 'armed' keeps the first
  // edge after reset release idle so no word appears before the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0   <= '0;
      ch_p0     <= '0;
      vld_p0    <= 1'b0;
      scan_p0   <= 1'b0;
      ptr       <= '0;
      dcnt      <= '0;
      prev_mode <= 1'b0;
      armed     <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else begin
      prev_mode <= mode;
      if (mode) begin
        ptr  <= cptr;
        dcnt <= cdcnt;
      end
      if (load) begin
        if (!mode) begin
          if (sel_ok && ch_en[sel]) begin
            data_p0 <= ch_arr[sel];
            ch_p0   <= sel;
            vld_p0  <= 1'b1;
            scan_p0 <= 1'b0;
          end else begin
            vld_p0  <= 1'b0;
          end
        end else if (ch_en[cptr]) begin
          data_p0 <= ch_arr[cptr];
          ch_p0   <= cptr;
          vld_p0  <= 1'b1;
          scan_p0 <= 1'b1;
        end else begin
          // Disabled channel under the pointer: one bubble, then move on.
          // With no channel enabled at all, pointer and counter hold.
          vld_p0 <= 1'b0;
          if (|ch_en) begin
            ptr  <= next_en(cptr, ch_en);
            dcnt <= '0;
          end
        end
      end
    end
  end

  assign out_data  = data_p0;
  assign out_ch    = ch_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan (NUM_CH=8, DATA_W=8): table-driven manual-mode
// vectors plus hand-written scan, backpressure and reset sequences.
module tb_mux_nto1_scan;

  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 8;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 4;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CH-1:0]        ch_en;
  logic [DWELL_W-1:0]       dwell;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;

  int total;
  int passed;

  mux_nto1_scan #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DWELL_W(DWELL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .sel(sel),
    .ch_en(ch_en), .dwell(dwell), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] en;
    logic       vld;
    logic [7:0] data;
    logic [2:0] ch;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] exp_seq [10];
  int exp_ch;
  int accepts;
  logic [2:0] held_ch;

  initial begin
    total   = 0;
    passed  = 0;
    rst_n   = 1'b0;
    mode    = 1'b0;
    sel     = '0;
    ch_en   = 8'hFF;
    dwell   = '0;
    out_ready = 1'b1;
    for (int k = 0; k < NUM_CH; k++) in_data[k*DATA_W +: DATA_W] = 8'hA0 + 8'(k);

    for (int k = 0; k < 8; k++) tbl[k] = '{3'(k), 8'hFF, 1'b1, 8'hA0 + 8'(k), 3'(k)};
    tbl[8] = '{3'd3, 8'hF7, 1'b0, 8'h00, 3'd0};
    tbl[9] = '{3'd3, 8'hFF, 1'b1, 8'hA3, 3'd3};

    // Reset state before any clock edge.
    #1;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_data", 32'(out_data), 0);
    chk("reset_ch", 32'(out_ch), 0);

    step();
    step();
    rst_n = 1'b1;
    // First edge after release stays idle.
    step();
    chk("first_edge_idle", 32'(out_valid), 0);

    // Manual-mode table.
    for (int i = 0; i < 10; i++) begin
      sel   = tbl[i].sel;
      ch_en = tbl[i].en;
      step();
      chk($sformatf("man_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("man_data[%0d]", i), 32'(out_data), 32'(tbl[i].data));
        chk($sformatf("man_ch[%0d]", i), 32'(out_ch), 32'(tbl[i].ch));
      end
    end

    // Backpressure: A2 held while sel moves to 6.
    sel = 3'd2;
    step();
    chk("bp_load_data", 32'(out_data), 32'h A2);
    out_ready = 1'b0;
    sel = 3'd6;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold_data[%0d]", i), 32'(out_data), 32'hA2);
      chk($sformatf("bp_hold_ch[%0d]", i), 32'(out_ch), 2);
      chk($sformatf("bp_hold_valid[%0d]", i), 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_data", 32'(out_data), 32'hA6);
    chk("bp_release_ch", 32'(out_ch), 6);

    // Scan with ch_en = 1010_0101, dwell = 1, start at channel 2.
    exp_seq = '{3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7, 3'd0, 3'd0, 3'd2, 3'd2};
    ch_en = 8'b1010_0101;
    dwell = 4'd1;
    sel   = 3'd2;
    mode  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("scan_valid[%0d]", i), 32'(out_valid), 1);
      chk($sformatf("scan_ch[%0d]", i), 32'(out_ch), 32'(exp_seq[i]));
      chk($sformatf("scan_data[%0d]", i), 32'(out_data), 32'hA0 + 32'(exp_seq[i]));
    end

    // Re-enter scan at channel 0 with dwell 0 and random backpressure.
    mode  = 1'b0;
    sel   = 3'd0;
    ch_en = 8'hFF;
    dwell = 4'd0;
    step();
    mode = 1'b1;
    step();
    exp_ch  = 0;
    accepts = 0;
    for (int c = 0; c < 200; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        chk($sformatf("rr_ch[%0d]", accepts), 32'(out_ch), 32'(exp_ch));
        chk($sformatf("rr_data[%0d]", accepts), 32'(out_data), 32'hA0 + 32'(exp_ch));
        exp_ch = (exp_ch + 1) % NUM_CH;
        accepts++;
      end
      step();
    end
    chk("rr_enough_accepts", 32'(accepts >= 16), 1);

    // ch_en cleared while a word is stalled: word stays, then valid drops.
    out_ready = 1'b0;
    step();
    held_ch = out_ch;
    chk("en0_have_word", 32'(out_valid), 1);
    ch_en = 8'h00;
    step();
    chk("en0_hold_valid", 32'(out_valid), 1);
    chk("en0_hold_ch", 32'(out_ch), 32'(held_ch));
    out_ready = 1'b1;
    step();
    chk("en0_drop_valid", 32'(out_valid), 0);
    step();
    chk("en0_stay_low", 32'(out_valid), 0);

    // Async reset in the middle of a stall.
    ch_en = 8'hFF;
    step();
    out_ready = 1'b0;
    step();
    chk("rst_pre_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    chk("async_rst_ch", 32'(out_ch), 0);

    // Recovery: manual sel 1, first word only at the second edge.
    mode = 1'b0;
    sel  = 3'd1;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_edge1", 32'(out_valid), 0);
    step();
    chk("post_rst_edge2_valid", 32'(out_valid), 1);
    chk("post_rst_edge2_data", 32'(out_data), 32'hA1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global timeout guard.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
